download_buffer: RTL
====================

Name: download_buffer

Overview:
- Elastic buffer between the HPS ioctl download bus and the core's download port.
- Captures 16-bit ROM words with their byte addresses into a small FIFO.
- Throttles the HPS with ioctl_wait when the FIFO nears full.
- Presents words downstream with a valid/ready handshake, framed by a download-active signal and a completion pulse, so slow SDRAM/DDR writers never drop data.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 8.
- HIGH_WATER, 12: occupancy at which ioctl_wait asserts; must be at most DEPTH-2.
- ADDR_WIDTH, 25: ioctl address width.
- DATA_WIDTH, 16: ioctl data width.
- INDEX_WIDTH, 8: ioctl index width.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  HPS download in progress.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  ADDR_WIDTH  byte address of the word.
- ioctl_dout  in  DATA_WIDTH  word data.
- ioctl_index  in  INDEX_WIDTH  file/ROM index.
- ioctl_wait  out  1  back-pressure to HPS.
- out_cs  out  1  download active downstream.
- out_index  out  INDEX_WIDTH  latched index for the current download.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer accepts head word.
- out_addr  out  ADDR_WIDTH  head word address.
- out_data  out  DATA_WIDTH  head word data.
- out_done  out  1  one-cycle pulse when a download has fully drained.
- overflow  out  1  sticky flag: a write was dropped.

Behaviour:
- Reset: synchronous, active-high; "already decided" rule: one clock, named clock; reset named reset, synchronous, active-high.
- Reset clears:
  - FIFO pointers and count to 0.
  - ioctl_wait, out_cs, out_valid, out_done and overflow to 0.
  - out_index, out_addr and out_data to 0.
- Reset mid-download discards all buffered words. No out_done is issued.
- State machine has three states: IDLE, ACTIVE, DRAIN.
  - IDLE -> ACTIVE on a rising edge of ioctl_download, provided count==0. On entry, latch out_index from ioctl_index and set out_cs=1 in the same cycle as the transition, i.e. registered, visible the next cycle.
  - A rising edge seen while not in IDLE is held pending. ioctl_wait stays 1 until the FSM reaches IDLE, then ACTIVE is entered on the following cycle.
  - ACTIVE -> DRAIN when ioctl_download falls.
  - DRAIN -> IDLE when count==0 and no pop is pending. That cycle pulses out_done=1 for exactly 1 cycle and drops out_cs to 0 simultaneously.
- Push:
  - Occurs when ioctl_wr & ioctl_download & state==ACTIVE.
  - Accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - If full without a pop, the word is dropped and overflow is set (sticky until reset).
  - ioctl_wr outside ACTIVE is ignored and does not set overflow.
- Pop occurs when out_valid & out_ready.
- Simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo DEPTH.
- Output is first-word fall-through:
  - out_valid = (count!=0), registered.
  - A word pushed in cycle N appears on out_addr/out_data with out_valid=1 in cycle N+1.
  - out_addr and out_data hold stable while out_valid & !out_ready.
- ioctl_wait is registered: 1 when count >= HIGH_WATER, or a start is pending, else 0. The DEPTH-HIGH_WATER margin absorbs writes issued during the one-cycle wait latency.
- out_cs is 1 from the cycle after ACTIVE entry through the cycle before out_done. It is 0 during out_done.

Test Plan:
- Streaming write: index=0x03, 8 words with addr 0,2,...,14 and data 0xA000+i, out_ready=1 → 8 pops in order, each 1 cycle after its push. out_index=0x03. ioctl_wait never asserts. One out_done after download falls. overflow=0.
- Back-pressure: out_ready=0, writes every cycle → ioctl_wait=1 the cycle after count reaches 12. The HPS model stops, no drops occur, and count stays ≤16.
- Overflow: out_ready=0, a rogue writer ignores wait and issues 17 writes → the 17th is dropped and overflow=1 sticks. The first 16 words drain intact when out_ready=1.
- Full simultaneous push/pop: count=16, out_ready=1 with ioctl_wr in the same cycle → word accepted, count stays 16, overflow=0.
- Back-to-back downloads: the second rising edge arrives while 5 words remain → ioctl_wait=1 until drained. out_done is pulsed. The new index is latched only after IDLE, and the second file's words are not interleaved with the first.
- Mid-download reset: reset=1 for 1 cycle with 6 words buffered → next cycle count=0, out_valid=0, out_cs=0, out_done never pulses, ioctl_wait=0.

Source files
------------

// File: rtl/download_buffer.sv
// Elastic FIFO between the HPS ioctl download bus and the core's download port.
// Buffers address/data words, throttles the HPS with ioctl_wait, frames the stream downstream.
module download_buffer #(
  parameter int DEPTH       = 16,
  parameter int HIGH_WATER  = 12,
  parameter int ADDR_WIDTH  = 25,
  parameter int DATA_WIDTH  = 16,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [ADDR_WIDTH-1:0]  ioctl_addr,
  input  logic [DATA_WIDTH-1:0]  ioctl_dout,
  input  logic [INDEX_WIDTH-1:0] ioctl_index,
  output logic                   ioctl_wait,
  output logic                   out_cs,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_done,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt, count_after_pop;
  logic             download_p1;
  logic             rise, start, start_pending;
  logic             push_req, push, pop, drop, done_nxt;

  always_comb begin
    rise            = ioctl_download & ~download_p1;
    pop             = out_valid & out_ready;
    push_req        = ioctl_wr & ioctl_download & (state == ACTIVE);
    push            = push_req & ((count < CNT_W'(DEPTH)) | pop);
    drop            = push_req & ~push;
    start           = (state == IDLE) & (count == '0) & (rise | start_pending);
    count_after_pop = count - CNT_W'(pop);
    count_nxt       = count_after_pop + CNT_W'(push);
    rd_ptr_nxt      = rd_ptr + PTR_W'(pop);
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = ACTIVE;
      ACTIVE:  if (!ioctl_download) state_nxt = DRAIN;
      DRAIN: begin
        // out_valid mirrors count!=0, so an empty FIFO cannot have a pop in flight
        if (count == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge detector samples through reset so a download already high is not seen as new
  always_ff @(posedge clock) begin
    download_p1 <= ioctl_download;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_addr[wr_ptr] <= ioctl_addr;
      mem_data[wr_ptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      start_pending <= 1'b0;
      ioctl_wait    <= 1'b0;
      out_cs        <= 1'b0;
      out_index     <= '0;
      out_done      <= 1'b0;
      overflow      <= 1'b0;
      out_valid     <= 1'b0;
      out_addr      <= '0;
      out_data      <= '0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);

      if (start)     start_pending <= 1'b0;
      else if (rise) start_pending <= 1'b1;

      ioctl_wait <= (count >= CNT_W'(HIGH_WATER)) | start_pending;
      out_done   <= done_nxt;
      if (start) begin
        out_cs    <= 1'b1;
        out_index <= ioctl_index;
      end else if (done_nxt) begin
        out_cs <= 1'b0;
      end
      if (drop) overflow <= 1'b1;

      // First-word fall-through: a push into an otherwise empty FIFO bypasses memory
      out_valid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        if (push && (count_after_pop == '0)) begin
          out_addr <= ioctl_addr;
          out_data <= ioctl_dout;
        end else begin
          out_addr <= mem_addr[rd_ptr_nxt];
          out_data <= mem_data[rd_ptr_nxt];
        end
      end
    end
  end

endmodule
